// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the fetch sequencer: FSM states, widths, entry layout.
package pc_fetch_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 16;
  localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FULL  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_fifo.sv
// Two-entry instruction buffer; flush beats push and pop, push and pop may coincide.
module pc_fetch_fifo
  import pc_fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t mem [2];
  logic   wr_ptr;
  logic   rd_ptr;
  logic   do_push;
  logic   do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: one outstanding imem read, only issued when a buffer slot is free; redirects flush.
// PC_FETCH_PERF_EN adds saturating redirect / decode-starve counters.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEF,
  parameter int          INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int unsigned PC_INC   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               if_ready
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [15:0]        perf_redirects,
  output logic [15:0]        perf_starve
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [PC_W-1:0] req_pc, req_pc_nxt;
  logic            drop, drop_nxt;
  logic            push, pop;
  logic [1:0]      count, count_after;
  entry_t          head, push_data;

  assign pop         = if_valid && if_ready && !redirect_valid;
  assign push        = (state == WAIT) && imem_rvalid && !drop && !redirect_valid;
  assign count_after = redirect_valid ? 2'd0 : count + 2'(push) - 2'(pop);
  assign push_data   = '{pc: req_pc, instr: imem_rdata};

  pc_fetch_fifo #(.entry_t(entry_t)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      drop     <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    drop_nxt     = drop;
    case (state)
      BOOT:  state_nxt = ISSUE;
      ISSUE: if (imem_gnt) begin
        req_pc_nxt   = fetch_pc;
        fetch_pc_nxt = fetch_pc + PC_W'(PC_INC);
        state_nxt    = WAIT;
      end
      WAIT:  if (imem_rvalid) begin
        drop_nxt  = 1'b0;
        state_nxt = (count_after < 2'd2) ? ISSUE : FULL;
      end
      FULL:  if (count_after < 2'd2) state_nxt = ISSUE;
      default: state_nxt = BOOT;
    endcase
    // A redirect zeroes count_after, so the plain transitions already land in ISSUE/WAIT;
    // only the fate of a response still in flight needs handling here.
    if (redirect_valid) begin
      fetch_pc_nxt = redirect_pc;
      if (((state == ISSUE) && imem_gnt) || ((state == WAIT) && !imem_rvalid)) drop_nxt = 1'b1;
    end
  end

  assign imem_req  = (state == ISSUE);
  assign imem_addr = fetch_pc;
  assign if_valid  = (count != 2'd0);
  assign if_instr  = head.instr;
  assign if_pc     = head.pc;

`ifdef PC_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirects <= 16'd0;
      perf_starve    <= 16'd0;
    end else begin
      if (redirect_valid && (perf_redirects != 16'hFFFF)) perf_redirects <= perf_redirects + 16'd1;
      if (if_ready && !if_valid && (perf_starve != 16'hFFFF)) perf_starve <= perf_starve + 16'd1;
    end
  end
`else
  // Counters compiled out.
`endif

endmodule
